// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester handshake and the transmitter handshake of the
// uart_tx arbiter. Signal names follow the arbiter's point of view.
//   i_req       per-requester request level
//   i_data      requester k byte at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_ack       one-cycle pulse, requester k byte sent
//   o_tx_start  start strobe to the transmitter
//   o_tx_data   byte to the transmitter
//   i_tx_done   done strobe from the transmitter
//   o_busy      transfer in progress
//   o_grant_id  index of current/last granted requester
//   o_timeout   one-cycle pulse when a transfer is aborted
// modport slave  : the arbiter
// modport master : the requesters/transmitter side (or a testbench)
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            i_req;
    logic [N_REQ*DATA_WIDTH-1:0] i_data;
    logic [N_REQ-1:0]            o_ack;
    logic                        o_tx_start;
    logic [DATA_WIDTH-1:0]       o_tx_data;
    logic                        i_tx_done;
    logic                        o_busy;
    logic [ID_W-1:0]             o_grant_id;
    logic                        o_timeout;

    modport slave (
        input  i_req, i_data, i_tx_done,
        output o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout
    );

    modport master (
        output i_req, i_data, i_tx_done,
        input  o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx transmitter between N_REQ byte requesters. Grants one
// requester at a time in round-robin order, latches its byte, strobes the
// transmitter for one cycle and waits for its done pulse. The winner is acked,
// or a timeout pulse is raised if the transmitter never completes.
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    uart_tx_arbiter_if.slave (requester and transmitter handshakes)
// All outputs are registered.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no transfer; pick next requester, latch its byte
// S_ISSUE | o_tx_start high for this one cycle, load timeout counter
// S_WAIT  | wait for i_tx_done or timeout, o_tx_data held stable
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ID_W-1:0]       r_last_grant;
    logic [ID_W-1:0]       r_grant;
    logic [N_REQ-1:0]      r_ack;
    logic                  r_tx_start;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_busy;
    logic                  r_timeout;

    logic                  w_found;
    logic [ID_W-1:0]       w_idx;
    logic [ID_W-1:0]       w_next_id;
    logic [DATA_WIDTH-1:0] w_next_data;

    // Round-robin search starting one past the last winner; the last winner
    // itself is visited last, so a held request cannot starve the others.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = '0;
        w_next_id = r_last_grant;
        for (int off = 1; off <= N_REQ; off++) begin
            w_idx = ID_W'((int'(r_last_grant) + off) % N_REQ);
            if (!w_found && bus.i_req[w_idx]) begin
                w_found   = 1'b1;
                w_next_id = w_idx;
            end
        end
    end

    always_comb begin
        w_next_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_next_id == ID_W'(k)) begin
                w_next_data = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The timeout counter runs down from TIMEOUT_CYCLES-1, so reaching zero
    // marks the TIMEOUT_CYCLES-th cycle spent in S_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= LAST_RST;
            r_grant      <= '0;
            r_ack        <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_next_id;
                        r_tx_data  <= w_next_data;
                        r_busy     <= 1'b1;
                        r_tx_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a coincident timeout
                    if (bus.i_tx_done) begin
                        r_ack        <= N_REQ'(1) << r_grant;
                        r_busy       <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_timeout    <= 1'b1;
                        r_busy       <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ack      = r_ack;
    assign bus.o_tx_start = r_tx_start;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_busy     = r_busy;
    assign bus.o_grant_id = r_grant;
    assign bus.o_timeout  = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int N_REQ    = 4;
    localparam int DW       = 8;
    localparam int TO_SHORT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) bus ();
    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) bus_to ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_SHORT)) u_dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_to.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: one entry per expected transfer, peeked at start, popped at ack
    typedef struct {
        logic [1:0] grant;
        logic [7:0] data;
    } exp_t;
    exp_t q_exp[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.o_tx_start) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_start", bus.o_tx_start, 0);
                end else begin
                    chk("start_grant", bus.o_grant_id, q_exp[0].grant);
                    chk("start_data", bus.o_tx_data, q_exp[0].data);
                    chk("start_busy", bus.o_busy, 1);
                end
            end
            if (bus.o_ack != 0) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_ack", bus.o_ack, 0);
                end else begin
                    mon_e = q_exp.pop_front();
                    chk("ack_onehot", bus.o_ack, 4'b0001 << mon_e.grant);
                    chk("ack_busy", bus.o_busy, 0);
                    chk("ack_txdata_held", bus.o_tx_data, mon_e.data);
                end
            end
            if (bus.o_timeout) chk("unexpected_timeout", bus.o_timeout, 0);
        end
    end

    // transmitter model: done pulse resp_dly cycles after the start strobe
    logic resp_done = 1'b0;
    logic man_done  = 1'b0;
    logic resp_en   = 1'b1;
    int   resp_dly  = 1;
    int   resp_cnt  = 0;
    assign bus.i_tx_done = resp_done | man_done;

    initial forever begin
        @(negedge clk);
        resp_done = 1'b0;
        if (reset || !resp_en) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) resp_done = 1'b1;
            end
            if (bus.o_tx_start) resp_cnt = resp_dly;
        end
    end

    task automatic wait_ack(input string name, input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.o_ack == 0 && t < budget);
        chk({name, "_ack_seen"}, (bus.o_ack != 0), 1);
    endtask

    task automatic wait_start(input string name, input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.o_tx_start && t < budget);
        chk({name, "_start_seen"}, bus.o_tx_start, 1);
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.grant = g;
        e.data  = d;
        q_exp.push_back(e);
    endtask

    task automatic xfer_one(input logic [3:0] req, input logic [31:0] data, input int dly,
                            input logic [1:0] eg, input string name);
        @(negedge clk);
        push_exp(eg, data[int'(eg)*8 +: 8]);
        resp_dly   = dly;
        bus.i_data = data;
        bus.i_req  = req;
        wait_ack(name, dly + 20);
        chk({name, "_gid"}, bus.o_grant_id, eg);
        bus.i_req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        bus.i_req  = '0;
        q_exp.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ack"}, bus.o_ack, 0);
        chk({name, "_start"}, bus.o_tx_start, 0);
        chk({name, "_txdata"}, bus.o_tx_data, 0);
        chk({name, "_busy"}, bus.o_busy, 0);
        chk({name, "_gid"}, bus.o_grant_id, 0);
        chk({name, "_timeout"}, bus.o_timeout, 0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          dly;
        logic [1:0]  grant;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   t;
        logic got_ack;

        // last_grant evolves 3 -> 2 -> 0 -> 3 -> 0 -> 1 -> 0 through the table
        vecs[0] = '{4'b0100, 32'h00A5_0000, 20, 2'd2};
        vecs[1] = '{4'b0011, 32'h0000_2211, 3,  2'd0};
        vecs[2] = '{4'b1001, 32'h4400_0033, 1,  2'd3};
        vecs[3] = '{4'b1001, 32'h5500_0066, 5,  2'd0};
        vecs[4] = '{4'b0010, 32'h0000_7700, 2,  2'd1};
        vecs[5] = '{4'b0001, 32'h0000_0088, 7,  2'd0};

        reset          = 1'b1;
        bus.i_req      = '0;
        bus.i_data     = '0;
        bus_to.i_req   = '0;
        bus_to.i_data  = '0;
        bus_to.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // T4: short-timeout instance, transmitter never answers
        @(negedge clk);
        bus_to.i_data = 32'h0000_2B1A;
        bus_to.i_req  = 4'b0011;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus_to.o_tx_start && t < 10);
        chk("t4_start", bus_to.o_tx_start, 1);
        chk("t4_grant", bus_to.o_grant_id, 0);
        chk("t4_data", bus_to.o_tx_data, 8'h1A);
        t = 0;
        got_ack = 1'b0;
        do begin
            @(negedge clk);
            t++;
            if (bus_to.o_ack != 0) got_ack = 1'b1;
        end while (!bus_to.o_timeout && t < 40);
        chk("t4_timeout_latency", t, TO_SHORT + 1);
        chk("t4_no_ack", got_ack, 0);
        chk("t4_busy_low", bus_to.o_busy, 0);
        @(negedge clk);
        chk("t4_timeout_pulse", bus_to.o_timeout, 0);
        chk("t4_retry_start", bus_to.o_tx_start, 1);
        chk("t4_retry_grant", bus_to.o_grant_id, 1);
        chk("t4_retry_data", bus_to.o_tx_data, 8'h2B);
        bus_to.i_req = '0;

        // T1 and table of single transfers
        for (int i = 0; i < 6; i++) begin
            xfer_one(vecs[i].req, vecs[i].data, vecs[i].dly, vecs[i].grant, $sformatf("v%0d", i));
        end

        // T2: all four held after reset
        do_reset();
        @(negedge clk);
        bus.i_data = 32'hD3C2_B1A0;
        push_exp(2'd0, 8'hA0);
        push_exp(2'd1, 8'hB1);
        push_exp(2'd2, 8'hC2);
        push_exp(2'd3, 8'hD3);
        push_exp(2'd0, 8'hA0);
        resp_dly  = 4;
        bus.i_req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_ack($sformatf("t2_%0d", i), 40);
        bus.i_req = '0;
        repeat (6) @(negedge clk);
        chk("t2_queue_empty", q_exp.size(), 0);

        // T3: req0 held, req1 asserted -> alternate
        do_reset();
        @(negedge clk);
        bus.i_data = 32'h0000_E1E0;
        push_exp(2'd0, 8'hE0);
        push_exp(2'd1, 8'hE1);
        push_exp(2'd0, 8'hE0);
        push_exp(2'd1, 8'hE1);
        resp_dly  = 2;
        bus.i_req = 4'b0011;
        for (int i = 0; i < 4; i++) wait_ack($sformatf("t3_%0d", i), 40);
        bus.i_req = '0;
        repeat (6) @(negedge clk);
        chk("t3_queue_empty", q_exp.size(), 0);

        // T5: reset during WAIT (last_grant=1 so req2 wins)
        @(negedge clk);
        push_exp(2'd2, 8'h5C);
        resp_dly   = 50;
        bus.i_data = 32'h005C_0000;
        bus.i_req  = 4'b0100;
        wait_start("t5", 10);
        repeat (5) @(negedge clk);
        chk("t5_busy_in_wait", bus.o_busy, 1);
        reset     = 1'b1;
        bus.i_req = '0;
        q_exp.delete();
        @(negedge clk);
        chk_reset_vals("t5_rst");
        reset = 1'b0;
        xfer_one(4'b1000, 32'h9D00_0000, 3, 2'd3, "t5_after");

        // T6: done in IDLE and ISSUE is ignored, only WAIT done acks
        resp_en = 1'b0;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_busy", bus.o_busy, 0);
        push_exp(2'd0, 8'hC6);
        bus.i_data = 32'h0000_00C6;
        bus.i_req  = 4'b0001;
        wait_start("t6", 10);
        man_done  = 1'b1;
        bus.i_req = '0;
        @(negedge clk);
        man_done = 1'b0;
        got_ack  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_ack != 0) got_ack = 1'b1;
        end
        chk("t6_issue_done_ignored", got_ack, 0);
        chk("t6_still_busy", bus.o_busy, 1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        chk("t6_wait_ack", bus.o_ack, 4'b0001);
        resp_en = 1'b1;

        repeat (5) @(negedge clk);
        chk("final_queue_empty", q_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
